// File: rtl/conv_pkg.sv
// conv_pkg: shared fixed-point helpers for the streaming convolution layer.
package conv_pkg;
    function automatic int acc_width(input int dw);
        return 2 * dw + 6;
    endfunction
    function automatic int widx(input int r, input int c, input int k);
        return r * k + c;
    endfunction
    // Arithmetic shift: truncates toward minus infinity.
    function automatic longint shr(input longint x, input int f);
        return x >>> f;
    endfunction
    function automatic longint sat(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: ROWS chained row delays of DEPTH words, addressed by the column counter.
module conv_line_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int ROWS  = 3
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic signed [WIDTH-1:0]  din,
    output logic signed [WIDTH-1:0]  taps [ROWS]
);
    logic signed [WIDTH-1:0] row_in [ROWS];
    assign row_in[0] = din;
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        logic signed [WIDTH-1:0] mem [DEPTH];
        if (i > 0) begin : g_chain
            assign row_in[i] = taps[i-1];
        end
        // taps[i] is the pixel i+1 rows above the current column, read before overwrite.
        assign taps[i] = mem[addr];
        always_ff @(posedge clk)
            if (en) mem[addr] <= row_in[i];
    end
endmodule

// File: rtl/conv2d_kxk_stream_layer.sv
// conv2d_kxk_stream_layer: streaming KxK strided convolution with bias, saturation, optional
// ReLU and valid/ready flow control; outputs appear two enabled cycles after the window pixel.
module conv2d_kxk_stream_layer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int K          = 4,
    parameter int STRIDE     = 2,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic [K*K*DATA_WIDTH-1:0]    weights,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         relu_en,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         last_out
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int LAST_C = K - 1 + (IMG_WIDTH - K) / STRIDE * STRIDE;
    localparam int LAST_R = K - 1 + (IMG_HEIGHT - K) / STRIDE * STRIDE;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic en, accept, win_ok, win_last, v1, l1, v2, l2;
    logic signed [DATA_WIDTH-1:0] w [K*K];
    logic signed [DATA_WIDTH-1:0] taps [K-1];
    logic signed [DATA_WIDTH-1:0] col_in [K];
    logic signed [DATA_WIDTH-1:0] win [K][K];
    logic signed [PW-1:0] prod [K*K];
    logic signed [ACC_WIDTH-1:0] sum;
    longint s;
    logic signed [DATA_WIDTH-1:0] res;

    assign en = ready_out || !valid_out;
    assign ready_in = en;
    assign accept = valid_in && en;
    // Row gating via row >= K-1 keeps previous-frame line-buffer rows out of every window.
    assign win_ok = int'(col) >= K - 1 && int'(row) >= K - 1 &&
                    (int'(col) - K + 1) % STRIDE == 0 && (int'(row) - K + 1) % STRIDE == 0;
    assign win_last = int'(col) == LAST_C && int'(row) == LAST_R;

    conv_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ROWS(K - 1)) u_lb (
        .clk  (clk),
        .en   (accept),
        .addr (col),
        .din  (data_in),
        .taps (taps)
    );

    for (genvar i = 0; i < K * K; i++) begin : g_w
        assign w[i] = weights[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar r = 0; r < K - 1; r++) begin : g_col
        assign col_in[r] = taps[K-2-r];
    end
    assign col_in[K-1] = data_in;

    always_comb begin
        sum = ACC_WIDTH'(bias) <<< FRAC_BITS;
        for (int i = 0; i < K * K; i++) sum = sum + ACC_WIDTH'(prod[i]);
        s = sat(shr(longint'(sum), FRAC_BITS), DATA_WIDTH);
        res = relu_en && s < 0 ? '0 : s[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk)
        if (en) begin
            if (accept)
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                    win[r][K-1] <= col_in[r];
                end
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    prod[widx(r, c, K)] <= PW'(win[r][c]) * PW'(w[widx(r, c, K)]);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            v1 <= 1'b0;
            l1 <= 1'b0;
            v2 <= 1'b0;
            l2 <= 1'b0;
            valid_out <= 1'b0;
            last_out <= 1'b0;
            data_out <= '0;
        end else if (en) begin
            if (accept) begin
                col <= int'(col) == IMG_WIDTH - 1 ? '0 : col + 1'b1;
                if (int'(col) == IMG_WIDTH - 1) row <= int'(row) == IMG_HEIGHT - 1 ? '0 : row + 1'b1;
            end
            v1 <= accept && win_ok;
            l1 <= accept && win_last;
            v2 <= v1;
            l2 <= l1;
            valid_out <= v2;
            last_out <= l2;
            if (v2) data_out <= res;
        end
endmodule

// File: tb/tb_conv2d_kxk_stream_layer.sv
// tb_conv2d_kxk_stream_layer: table vectors, randomized frames with backpressure checked against
// a direct-formula convolution model, a K=3 stride-1 latency case and a mid-frame reset.
module tb_conv2d_kxk_stream_layer;
    localparam int W = 8, H = 8, K = 4, S = 2, DW = 16, F = 8, OW = 3, OH = 3, K3 = 3;
    localparam longint SC = longint'(1) << F;

    typedef struct {logic signed [DW-1:0] d; logic l;} out_t;
    typedef struct {int pix; int w; int b; bit relu; int exp;} vec_t;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic valid_in = 0, ready_in, valid_out, ready_out = 1, last_out, relu_en = 0;
    logic signed [DW-1:0] data_in = 0, data_out, bias = 0;
    logic [K*K*DW-1:0] weights = '0;

    logic b_valid_in = 0, b_ready_in, b_valid_out, b_last_out;
    logic signed [DW-1:0] b_data_in = 0, b_data_out;
    logic [K3*K3*DW-1:0] b_weights = '0;

    conv2d_kxk_stream_layer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .FRAC_BITS(F),
                              .K(K), .STRIDE(S)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .weights(weights), .bias(bias), .relu_en(relu_en), .valid_out(valid_out),
        .ready_out(ready_out), .data_out(data_out), .last_out(last_out)
    );

    conv2d_kxk_stream_layer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .FRAC_BITS(0),
                              .K(K3), .STRIDE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(b_valid_in), .ready_in(b_ready_in),
        .data_in(b_data_in), .weights(b_weights), .bias(16'sd0), .relu_en(1'b0),
        .valid_out(b_valid_out), .ready_out(1'b1), .data_out(b_data_out), .last_out(b_last_out)
    );

    int total = 0, bad = 0;
    out_t q[$];
    int px [H][W];
    int wt [K*K];
    bit bp = 0, gaps = 0, ro_hold = 1;

    always @(posedge clk) begin
        #1;
        ready_out = bp ? 1'($urandom_range(0, 1)) : ro_hold;
    end

    logic stalled = 0;
    logic signed [DW-1:0] hold_d;
    logic hold_l;
    out_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) stalled = 0;
        else begin
            if (stalled) begin
                total++;
                if (!valid_out || data_out !== hold_d || last_out !== hold_l) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%0b data=%0d last=%0b, need valid=1 data=%0d last=%0b",
                             valid_out, data_out, last_out, hold_d, hold_l);
                end
            end
            if (valid_out && ready_out) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_output: data=%0d last=%0b, none expected", data_out, last_out);
                end else begin
                    mon_e = q.pop_front();
                    if (data_out !== mon_e.d || last_out !== mon_e.l) begin
                        bad++;
                        $display("FAIL out_check: data=%0d last=%0b, need data=%0d last=%0b",
                                 data_out, last_out, mon_e.d, mon_e.l);
                    end
                end
            end
            stalled = valid_out && !ready_out;
            hold_d = data_out;
            hold_l = last_out;
        end
    end

    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", n, a, e);
        end
    endtask

    task automatic set_w();
        for (int i = 0; i < K * K; i++) weights[i*DW +: DW] = DW'(wt[i]);
    endtask

    // Reference: direct strided sum over the frame, floor division by 2^F, clamp, ReLU.
    task automatic push_frame(input int bv, input bit relu);
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                longint t;
                out_t e;
                t = longint'(bv) * SC;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        t += longint'(px[oy*S+r][ox*S+c]) * longint'(wt[r*K+c]);
                t = t >= 0 ? t / SC : -((-t + SC - 1) / SC);
                if (t > 32767) t = 32767;
                else if (t < -32768) t = -32768;
                if (relu && t < 0) t = 0;
                e.d = DW'(t);
                e.l = oy == OH - 1 && ox == OW - 1;
                q.push_back(e);
            end
    endtask

    task automatic send(input int p);
        int n = 0;
        valid_in = 1;
        data_in = DW'(p);
        while (1) begin
            @(negedge clk);
            if (ready_in) break;
            if (++n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: ready_in=0 for %0d cycles, need 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int npix);
        for (int i = 0; i < npix; i++) send(px[i/W][i%W]);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d outputs missing, need 0", q.size());
            q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic rand_frame(input int lim);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) px[r][c] = int'($urandom_range(0, 2 * lim)) - lim;
    endtask

    task automatic rand_w(input int lim);
        for (int i = 0; i < K * K; i++) wt[i] = int'($urandom_range(0, 2 * lim)) - lim;
        set_w();
    endtask

    vec_t tv[8];

    initial begin
        int k, a18, first;
        tv[0] = '{256, 256, 0, 0, 4096};
        tv[1] = '{32767, 32767, 0, 0, 32767};
        tv[2] = '{32767, -32767, 0, 0, -32768};
        tv[3] = '{32767, -32767, 0, 1, 0};
        tv[4] = '{256, 256, -256, 1, 3840};
        tv[5] = '{-256, 256, 0, 0, -4096};
        tv[6] = '{-256, 256, 0, 1, 0};
        tv[7] = '{-3, 5, 0, 0, -1};
        b_weights[4*DW +: DW] = 16'sd1;
        #12;
        chk("reset_valid_out", valid_out, 0);
        chk("reset_last_out", last_out, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_ready_in", ready_in, 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;

        // K=3 stride-1 ramp: centre tap passes pixel (row-1,col-1) through.
        k = 0;
        a18 = 0;
        first = -1;
        for (int i = 0; i < 67; i++) begin
            b_valid_in = i < 64;
            b_data_in = DW'(i < 64 ? i : 0);
            @(negedge clk);
            if (i == 18) a18 = cyc + 1;
            if (b_valid_out) begin
                if (first < 0) first = cyc;
                chk("b_data", b_data_out, k < 36 ? (k / 6 + 1) * 8 + k % 6 + 1 : -1);
                chk("b_last", b_last_out, k == 35);
                k++;
            end
            @(posedge clk);
            #1;
        end
        b_valid_in = 0;
        chk("b_count", k, 36);
        chk("b_latency", first - a18, 2);
        chk("b_ready_in", b_ready_in, 1);

        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) px[r][c] = tv[v].pix;
            for (int i = 0; i < K * K; i++) wt[i] = tv[v].w;
            set_w();
            bias = DW'(tv[v].b);
            relu_en = tv[v].relu;
            for (int i = 0; i < OW * OH; i++) q.push_back('{d: DW'(tv[v].exp), l: i == OW * OH - 1});
            send_frame(W * H);
            drain();
        end

        // Ramp and random frames under random backpressure and input gaps.
        bp = 1;
        gaps = 1;
        bias = 0;
        relu_en = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) px[r][c] = r * 8 + c;
        rand_w(2000);
        push_frame(0, 0);
        send_frame(W * H);
        drain();
        for (int n = 0; n < 3; n++) begin
            rand_frame(1000);
            rand_w(1000);
            bias = DW'(int'($urandom_range(0, 2000)) - 1000);
            push_frame(bias, 0);
            send_frame(W * H);
            drain();
        end

        // Back-to-back identical frames with negative bias and ReLU.
        rand_frame(600);
        rand_w(600);
        bias = -16'sd256;
        relu_en = 1;
        push_frame(-256, 1);
        push_frame(-256, 1);
        send_frame(W * H);
        send_frame(W * H);
        drain();

        // Reset with an output stuck under backpressure, then a clean frame.
        bp = 0;
        gaps = 0;
        relu_en = 0;
        bias = 0;
        rand_frame(500);
        rand_w(500);
        push_frame(0, 0);
        send_frame(32);
        ro_hold = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("stuck_valid_out", valid_out, 1);
        rst_n = 0;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        ro_hold = 1;
        @(posedge clk);
        #1;
        rand_frame(800);
        push_frame(0, 0);
        send_frame(W * H);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1);
    end
endmodule
